// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, drives instruction memory and registers the
// fetched instruction into the IF/ID boundary with bubble, stall and redirect handling.
module fetch_stage #(
  parameter int unsigned               INST_LENGTH = 32,
  parameter int unsigned               PC_LENGTH   = 32,
  parameter logic [PC_LENGTH-1:0]      RESET_PC    = '0,
  parameter logic [INST_LENGTH-1:0]    NOP_INST    = INST_LENGTH'(32'h00000033)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   PCSel,
  input  logic [PC_LENGTH-1:0]   alu,
  input  logic                   stall,
  input  logic [INST_LENGTH-1:0] imem_data,
  output logic [PC_LENGTH-1:0]   imem_addr,
  output logic [INST_LENGTH-1:0] inst_hat,
  output logic [PC_LENGTH-1:0]   PC_hat,
  output logic                   valid,
  output logic                   misalign,
  output logic [31:0]            fetch_count
);

  typedef enum logic [0:0] {StBoot, StRun} state_e;

  state_e                 state_q, state_d;
  logic [PC_LENGTH-1:0]   pc_q, pc_d;
  logic [INST_LENGTH-1:0] inst_q, inst_d;
  logic [PC_LENGTH-1:0]   pc_hat_q, pc_hat_d;
  logic                   valid_q, valid_d;
  logic                   misalign_q, misalign_d;
  logic [31:0]            count_q, count_d;

  logic [PC_LENGTH-1:0]   redirect_pc;
  logic                   redirect_misaligned;

  // Redirect targets are forced word-aligned; misalignment is only reported, never trapped.
  assign redirect_pc         = {alu[PC_LENGTH-1:2], 2'b00};
  assign redirect_misaligned = (alu[1:0] != 2'b00);

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    inst_d     = inst_q;
    pc_hat_d   = pc_hat_q;
    valid_d    = valid_q;
    misalign_d = misalign_q;
    count_d    = count_q;

    unique case (state_q)
      StBoot: begin
        state_d  = StRun;
        pc_d     = RESET_PC;
        inst_d   = NOP_INST;
        pc_hat_d = '0;
        valid_d  = 1'b0;
      end
      StRun: begin
        if (PCSel) begin
          pc_d     = redirect_pc;
          inst_d   = NOP_INST;
          pc_hat_d = '0;
          valid_d  = 1'b0;
          if (redirect_misaligned) begin
            misalign_d = 1'b1;
          end
        end else if (!stall) begin
          pc_d     = pc_q + PC_LENGTH'(4);
          inst_d   = imem_data;
          pc_hat_d = pc_q;
          valid_d  = 1'b1;
          count_d  = count_q + 32'd1;
        end
      end
      default: begin
        state_d = StBoot;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StBoot;
      pc_q       <= RESET_PC;
      inst_q     <= NOP_INST;
      pc_hat_q   <= '0;
      valid_q    <= 1'b0;
      misalign_q <= 1'b0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      inst_q     <= inst_d;
      pc_hat_q   <= pc_hat_d;
      valid_q    <= valid_d;
      misalign_q <= misalign_d;
      count_q    <= count_d;
    end
  end

  assign imem_addr   = pc_q;
  assign inst_hat    = inst_q;
  assign PC_hat      = pc_hat_q;
  assign valid       = valid_q;
  assign misalign    = misalign_q;
  assign fetch_count = count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed and randomized checks of fetch_stage against a cycle-level behavioural model
// of the fetch rules (boot bubble, redirect, stall, advance, sticky misalign).
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst, PCSel, stall;
  logic [31:0] alu, imem_data, imem_addr, inst_hat, PC_hat, fetch_count;
  logic        valid, misalign;

  int unsigned total  = 0;
  int unsigned passed = 0;
  int unsigned failed = 0;
  bit          scramble = 1'b0;

  // Reference model state
  bit          m_booted;
  logic [31:0] m_pc, m_inst, m_pch, m_cnt;
  bit          m_valid, m_mis;

  fetch_stage dut (
    .clk        (clk),
    .rst        (rst),
    .PCSel      (PCSel),
    .alu        (alu),
    .stall      (stall),
    .imem_data  (imem_data),
    .imem_addr  (imem_addr),
    .inst_hat   (inst_hat),
    .PC_hat     (PC_hat),
    .valid      (valid),
    .misalign   (misalign),
    .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_fn(input logic [31:0] a, input bit scr);
    return scr ? (a ^ 32'h5A5A_1234) : a;
  endfunction

  always_comb imem_data = mem_fn(imem_addr, scramble);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input bit r, input bit ps, input logic [31:0] a, input bit st);
    if (r) begin
      m_booted = 0; m_pc = 32'h0; m_inst = 32'h33; m_pch = 0; m_valid = 0; m_mis = 0;
      m_cnt = 0;
    end else if (!m_booted) begin
      m_booted = 1; m_inst = 32'h33; m_pch = 0; m_valid = 0;
    end else if (ps) begin
      if (a % 4 != 0) m_mis = 1;
      m_pc = a - (a % 4); m_inst = 32'h33; m_pch = 0; m_valid = 0;
    end else if (!st) begin
      m_inst = mem_fn(m_pc, scramble); m_pch = m_pc; m_valid = 1;
      m_pc = m_pc + 4; m_cnt = m_cnt + 1;
    end
  endtask

  task automatic check_model();
    chk("imem_addr", imem_addr, m_pc);
    chk("inst_hat", inst_hat, m_inst);
    chk("PC_hat", PC_hat, m_pch);
    chk("valid", {31'b0, valid}, {31'b0, m_valid});
    chk("misalign", {31'b0, misalign}, {31'b0, m_mis});
    chk("fetch_count", fetch_count, m_cnt);
  endtask

  // Apply inputs, clock one edge, update the model, then sample away from the edge.
  task automatic step(input bit r, input bit ps, input logic [31:0] a, input bit st);
    rst = r; PCSel = ps; alu = a; stall = st;
    @(posedge clk);
    model_edge(r, ps, a, st);
    #1;
    check_model();
  endtask

  initial begin
    rst = 1; PCSel = 0; alu = 0; stall = 0;
    m_booted = 0; m_pc = 0; m_inst = 32'h33; m_pch = 0; m_valid = 0; m_mis = 0; m_cnt = 0;
    #2;

    // Reset state, including stall/PCSel asserted during reset
    step(1, 0, 0, 0);
    step(1, 1, 32'h123, 1);
    chk("rst_inst", inst_hat, 32'h00000033);
    chk("rst_addr", imem_addr, 32'h0);

    // Boot bubble, then two fetches with data == address
    step(0, 0, 0, 0);
    chk("boot_valid", {31'b0, valid}, 32'd0);
    step(0, 0, 0, 0);
    chk("e2_inst", inst_hat, 32'h0);
    chk("e2_valid", {31'b0, valid}, 32'd1);
    step(0, 0, 0, 0);
    chk("e3_inst", inst_hat, 32'h4);
    chk("e3_pchat", PC_hat, 32'h4);
    chk("e3_addr", imem_addr, 32'h8);

    // Advance to PC=0x10, stall three cycles
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("pre_stall_addr", imem_addr, 32'h10);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 32'hDEAD_BEE0, 1);
      chk("stall_addr", imem_addr, 32'h10);
      chk("stall_inst", inst_hat, 32'hC);
      chk("stall_cnt", fetch_count, 32'd4);
    end
    step(0, 0, 0, 0);
    chk("resume_pchat", PC_hat, 32'h10);

    // Redirect wins over a concurrent stall; exactly one bubble
    step(0, 1, 32'h200, 1);
    chk("br_inst", inst_hat, 32'h00000033);
    chk("br_valid", {31'b0, valid}, 32'd0);
    chk("br_addr", imem_addr, 32'h200);
    step(0, 0, 0, 0);
    chk("br_tgt_pchat", PC_hat, 32'h200);
    chk("br_tgt_valid", {31'b0, valid}, 32'd1);

    // Misaligned target: aligned down, sticky flag
    step(0, 1, 32'h103, 0);
    chk("mis_addr", imem_addr, 32'h100);
    chk("mis_flag", {31'b0, misalign}, 32'd1);
    step(0, 0, 0, 0);
    step(0, 1, 32'h40, 0);
    chk("mis_sticky", {31'b0, misalign}, 32'd1);
    step(1, 0, 0, 0);
    chk("mis_cleared", {31'b0, misalign}, 32'd0);

    // PC wrap at top of address space
    step(0, 0, 0, 0);
    step(0, 1, 32'hFFFF_FFFC, 0);
    step(0, 0, 0, 0);
    chk("wrap_pchat", PC_hat, 32'hFFFF_FFFC);
    chk("wrap_addr", imem_addr, 32'h0);
    chk("wrap_misalign", {31'b0, misalign}, 32'd0);

    // Reset concurrent with redirect and stall
    step(0, 0, 0, 0);
    step(1, 1, 32'h500, 1);
    chk("rst_ps_addr", imem_addr, 32'h0);
    chk("rst_ps_cnt", fetch_count, 32'd0);
    chk("rst_ps_valid", {31'b0, valid}, 32'd0);

    // Randomized traffic against the model
    scramble = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      bit r, ps, st;
      logic [31:0] a;
      r  = ($urandom_range(99) < 2);
      ps = ($urandom_range(99) < 12);
      st = ($urandom_range(99) < 25);
      a  = $urandom();
      if ($urandom_range(3) == 0) a = a & 32'h0000_0FFF;
      step(r, ps, a, st);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
